// File: rtl/n2r_pkg.sv
// Shared types and sizing helpers for the normal-to-ready sequencer.
package n2r_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } n2r_state_t;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int grp_rows(input int block_size, input int num_cores);
        return block_size * num_cores;
    endfunction

    function automatic int num_colblk(input int col, input int block_size);
        return col / block_size;
    endfunction

    function automatic int num_groups(input int row, input int block_size, input int num_cores);
        return row / (block_size * num_cores);
    endfunction

endpackage

// File: rtl/n2r_chunk_mux.sv
// Picks column block blk out of the G-row buffer and packs one chunk per core, core 0 in the MSBs.
module n2r_chunk_mux
    import n2r_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int COL        = 6,
    parameter int NUM_CORES  = 2,
    parameter int JW         = 2
) (
    input  logic [BLOCK_SIZE*NUM_CORES-1:0][WIDTH*COL-1:0] rows,
    input  logic [JW-1:0]                                  blk,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]          word
);

    localparam int NE = CHUNK_SIZE * NUM_CORES;

    always_comb begin
        word = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int k = 0; k < BLOCK_SIZE; k++) begin
                    word[WIDTH*(NE - (c*CHUNK_SIZE + r*BLOCK_SIZE + k)) - 1 -: WIDTH] =
                        rows[c*BLOCK_SIZE + r][WIDTH*(COL - (int'(blk)*BLOCK_SIZE + k)) - 1 -: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/n2r_ctrl.sv
// Reads G-row groups from the source memory and streams them out as per-core BLOCK_SIZE x BLOCK_SIZE chunks.
// Optional stall counter enabled by N2R_CTRL_STALL_CNT_EN.
module n2r_ctrl
    import n2r_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int ROW        = 4,
    parameter int COL        = 6,
    parameter int NUM_CORES  = 2,
    parameter int ADDR_W     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [ADDR_W-1:0]                      base_addr,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   rd_en,
    output logic [ADDR_W-1:0]                      rd_addr,
    input  logic [WIDTH*COL-1:0]                   rd_data,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]  out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
`ifdef N2R_CTRL_STALL_CNT_EN
    output logic                                   out_last,
    output logic [31:0]                            stall_cnt
`else
    output logic                                   out_last
`endif
);

    localparam int G   = grp_rows(BLOCK_SIZE, NUM_CORES);
    localparam int NCB = num_colblk(COL, BLOCK_SIZE);
    localparam int NG  = num_groups(ROW, BLOCK_SIZE, NUM_CORES);
    localparam int IW  = cnt_w(G + 1);
    localparam int CW  = cnt_w(G);
    localparam int JW  = cnt_w(NCB);
    localparam int GW  = cnt_w(NG);
    localparam int RW  = WIDTH * COL;
    localparam int OW  = WIDTH * CHUNK_SIZE * NUM_CORES;

    n2r_state_t state, state_nxt;

    logic [IW-1:0]         i_q;
    logic [JW-1:0]         j_q;
    logic [GW-1:0]         g_q;
    logic [ADDR_W-1:0]     base_q;
    logic [G-1:0][RW-1:0]  rows_q;
    logic [G-1:0][RW-1:0]  rows_next;
    logic [CW-1:0]         cap_idx;
    logic [JW-1:0]         sel_j;
    logic [OW-1:0]         mux_word;
    logic                  fill_rd, capture, fill_end, accept, last_j, last_g;

    // FILL runs G+1 cycles: reads on i=0..G-1, captures of row i-1 on i=1..G.
    assign fill_rd  = (state == ST_FILL) && (i_q < IW'(G));
    assign capture  = (state == ST_FILL) && (i_q != '0);
    assign fill_end = (state == ST_FILL) && (i_q == IW'(G));
    assign cap_idx  = CW'(i_q - IW'(1));
    assign accept   = (state == ST_DRAIN) && out_valid && out_ready;
    assign last_j   = (j_q == JW'(NCB - 1));
    assign last_g   = (g_q == GW'(NG - 1));
    assign sel_j    = (state == ST_DRAIN) ? JW'(j_q + JW'(1)) : '0;

    assign rd_en   = fill_rd;
    assign rd_addr = fill_rd ? ADDR_W'(base_q + ADDR_W'(g_q) * ADDR_W'(G) + ADDR_W'(i_q)) : '0;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    // The row landing this cycle is forwarded so the first chunk is ready right at the end of FILL.
    always_comb begin
        rows_next = rows_q;
        if (capture) begin
            rows_next[cap_idx] = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            rows_q[cap_idx] <= rd_data;
        end
    end

    n2r_chunk_mux #(
        .WIDTH      (WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .CHUNK_SIZE (CHUNK_SIZE),
        .COL        (COL),
        .NUM_CORES  (NUM_CORES),
        .JW         (JW)
    ) u_mux (
        .rows (rows_next),
        .blk  (sel_j),
        .word (mux_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FILL;
            ST_FILL:  if (fill_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (accept && last_j) state_nxt = last_g ? ST_DONE : ST_FILL;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q       <= '0;
            j_q       <= '0;
            g_q       <= '0;
            base_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        g_q    <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                    end
                end
                ST_FILL: begin
                    if (fill_end) begin
                        i_q       <= '0;
                        j_q       <= '0;
                        out_data  <= mux_word;
                        out_valid <= 1'b1;
                        out_last  <= last_g && (NCB == 1);
                    end else begin
                        i_q <= IW'(i_q + IW'(1));
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        if (!last_j) begin
                            j_q      <= JW'(j_q + JW'(1));
                            out_data <= mux_word;
                            out_last <= last_g && (JW'(j_q + JW'(1)) == JW'(NCB - 1));
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (!last_g) begin
                                g_q <= GW'(g_q + GW'(1));
                                i_q <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef N2R_CTRL_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_n2r_ctrl.sv
// Scoreboard bench: one default instance (single group) and one ROW=8 instance (two groups, wrapping base).
module tb_n2r_ctrl;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } exp_t;

    localparam logic [127:0] CHUNK0 = {16'd0, 16'd1, 16'd10, 16'd11, 16'd20, 16'd21, 16'd30, 16'd31};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           cyc = 0;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    logic         start_a = 1'b0, start_b = 1'b0;
    logic [7:0]   base_addr_a = '0, base_addr_b = '0;
    logic         busy_a, busy_b, done_a, done_b, rd_en_a, rd_en_b;
    logic [7:0]   rd_addr_a, rd_addr_b;
    logic [95:0]  rd_data_a = '0, rd_data_b = '0;
    logic [127:0] out_data_a, out_data_b;
    logic         out_valid_a, out_valid_b, out_last_a, out_last_b;
    logic         out_ready_a = 1'b1, out_ready_b = 1'b1;
`ifdef N2R_CTRL_STALL_CNT_EN
    logic [31:0]  stall_cnt_a, stall_cnt_b;
`endif

    exp_t         exp_q_a[$], exp_q_b[$];
    logic [7:0]   addr_q_a[$], addr_q_b[$];
    int           done_cnt_a = 0, done_cnt_b = 0;
    int           start_cyc_a = 0, start_cyc_b = 0;
    int           last_acc_a = 0, last_acc_b = 0, last_valid_b = 0;
    bit           seen_a = 0, seen_b = 0, held_a = 0, held_b = 0;
    bit           prev_done_a = 0, prev_done_b = 0, prev_valid_b = 0;
    logic [127:0] prev_data_a = '0, prev_data_b = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    n2r_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr_a),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
`ifdef N2R_CTRL_STALL_CNT_EN
        .out_last(out_last_a), .stall_cnt(stall_cnt_a)
`else
        .out_last(out_last_a)
`endif
    );

    n2r_ctrl #(.ROW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr_b),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
`ifdef N2R_CTRL_STALL_CNT_EN
        .out_last(out_last_b), .stall_cnt(stall_cnt_b)
`else
        .out_last(out_last_b)
`endif
    );

    // Matrix row r holds elements 10r+k.
    function automatic logic [95:0] row_word(input int r);
        logic [95:0] w;
        w = '0;
        for (int k = 0; k < 6; k++) w[16*(6-k)-1 -: 16] = 16'(10*r + k);
        return w;
    endfunction

    function automatic logic [127:0] exp_chunk(input int g, input int j);
        logic [127:0] w;
        w = '0;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
                for (int k = 0; k < 2; k++)
                    w[16*(8-(c*4 + r*2 + k))-1 -: 16] = 16'(10*(g*4 + c*2 + r) + j*2 + k);
        return w;
    endfunction

    // Source memories: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? row_word(int'(8'(rd_addr_a - 8'h00))) : {6{16'hBEEF}};
        rd_data_b <= rd_en_b ? row_word(int'(8'(rd_addr_b - 8'hFE))) : {6{16'hBEEF}};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] ea;
        if (!rst_n) begin
            held_a = 0;
            held_b = 0;
            prev_done_a = 0;
            prev_done_b = 0;
        end else begin
            if (rd_en_a) begin
                if (addr_q_a.size() == 0) check("rd_a_unexpected", {120'd0, rd_addr_a}, 128'd0);
                else begin ea = addr_q_a.pop_front(); check("rd_addr_a", {120'd0, rd_addr_a}, {120'd0, ea}); end
            end
            if (out_valid_a) begin
                if (!seen_a) begin seen_a = 1; check("first_valid_a", cyc - start_cyc_a, 6); end
                if (held_a) check("hold_a", out_data_a, prev_data_a);
                if (out_ready_a) begin
                    if (exp_q_a.size() == 0) check("chunk_a_unexpected", out_data_a, 128'd0);
                    else begin
                        e = exp_q_a.pop_front();
                        check("chunk_a", out_data_a, e.d);
                        check("last_a", {127'd0, out_last_a}, {127'd0, e.l});
                    end
                    last_acc_a = cyc;
                end
            end
            held_a = out_valid_a && !out_ready_a;
            prev_data_a = out_data_a;
            if (prev_done_a) check("busy_fall_a", {127'd0, busy_a}, 128'd0);
            if (done_a) begin done_cnt_a++; check("done_time_a", cyc, last_acc_a + 1); end
            prev_done_a = done_a;

            if (rd_en_b) begin
                if (addr_q_b.size() == 0) check("rd_b_unexpected", {120'd0, rd_addr_b}, 128'd0);
                else begin ea = addr_q_b.pop_front(); check("rd_addr_b", {120'd0, rd_addr_b}, {120'd0, ea}); end
            end
            if (out_valid_b) begin
                if (!seen_b) begin seen_b = 1; check("first_valid_b", cyc - start_cyc_b, 6); end
                else if (!prev_valid_b) check("group_gap_b", cyc - last_valid_b - 1, 5);
                if (held_b) check("hold_b", out_data_b, prev_data_b);
                if (out_ready_b) begin
                    if (exp_q_b.size() == 0) check("chunk_b_unexpected", out_data_b, 128'd0);
                    else begin
                        e = exp_q_b.pop_front();
                        check("chunk_b", out_data_b, e.d);
                        check("last_b", {127'd0, out_last_b}, {127'd0, e.l});
                    end
                    last_acc_b = cyc;
                end
                last_valid_b = cyc;
            end
            prev_valid_b = out_valid_b;
            held_b = out_valid_b && !out_ready_b;
            prev_data_b = out_data_b;
            if (prev_done_b) check("busy_fall_b", {127'd0, busy_b}, 128'd0);
            if (done_b) begin done_cnt_b++; check("done_time_b", cyc, last_acc_b + 1); end
            prev_done_b = done_b;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string name);
        check({name, "_valid"}, {127'd0, out_valid_a}, 128'd0);
        check({name, "_last"},  {127'd0, out_last_a}, 128'd0);
        check({name, "_data"},  out_data_a, 128'd0);
        check({name, "_ctl"},   {124'd0, busy_a, done_a, rd_en_a, 1'b0}, 128'd0);
        check({name, "_addr"},  {120'd0, rd_addr_a}, 128'd0);
    endtask

    task automatic push_a();
        exp_t e;
        for (int a = 0; a < 4; a++) addr_q_a.push_back(8'(a));
        e.d = CHUNK0;          e.l = 1'b0; exp_q_a.push_back(e);
        e.d = exp_chunk(0, 1); e.l = 1'b0; exp_q_a.push_back(e);
        e.d = exp_chunk(0, 2); e.l = 1'b1; exp_q_a.push_back(e);
    endtask

    // Cycle numbers are relative to the start cycle (cycle 0).
    task automatic scen_a(input int stall_at, input int stall_len, input int restart_at);
        int d0;
        push_a();
        d0 = done_cnt_a;
        base_addr_a = 8'h00;
        start_a = 1'b1;
        start_cyc_a = cyc;
        seen_a = 0;
        step(1);
        start_a = 1'b0;
        for (int c = 1; c < 40 && done_cnt_a == d0; c++) begin
            out_ready_a = !(c >= stall_at && c < stall_at + stall_len);
            start_a = (c == restart_at);
            base_addr_a = (c == restart_at) ? 8'h40 : 8'h00;
            step(1);
        end
        start_a = 1'b0;
        base_addr_a = 8'h00;
        out_ready_a = 1'b1;
        step(2);
        check("done_count_a", done_cnt_a - d0, 1);
        check("queue_empty_a", exp_q_a.size() + addr_q_a.size(), 0);
    endtask

    initial begin
        exp_t e;
        int d0;
        step(3);
        check_idle_a("reset_a");
        check("reset_b", {out_data_b, 3'b0}, {128'd0, busy_b, out_valid_b, rd_en_b});
`ifdef N2R_CTRL_STALL_CNT_EN
        check("reset_stall", {96'd0, stall_cnt_a}, 128'd0);
`endif
        rst_n = 1'b1;
        step(1);

        scen_a(-10, 0, -1);

        // Two groups, row addresses wrap through 0xFF.
        for (int a = 0; a < 8; a++) addr_q_b.push_back(8'(8'hFE + a));
        for (int g = 0; g < 2; g++)
            for (int j = 0; j < 3; j++) begin
                e.d = exp_chunk(g, j);
                e.l = (g == 1 && j == 2);
                exp_q_b.push_back(e);
            end
        d0 = done_cnt_b;
        base_addr_b = 8'hFE;
        start_b = 1'b1;
        start_cyc_b = cyc;
        seen_b = 0;
        step(1);
        start_b = 1'b0;
        for (int c = 1; c < 80 && done_cnt_b == d0; c++) step(1);
        step(2);
        check("done_count_b", done_cnt_b - d0, 1);
        check("queue_empty_b", exp_q_b.size() + addr_q_b.size(), 0);

        scen_a(7, 4, -1);
`ifdef N2R_CTRL_STALL_CNT_EN
        check("stall_cnt", {96'd0, stall_cnt_a}, 128'd4);
`endif

        scen_a(-10, 0, 7);
`ifdef N2R_CTRL_STALL_CNT_EN
        check("stall_cleared", {96'd0, stall_cnt_a}, 128'd0);
`endif

        // Reset in the middle of DRAIN while chunk 1 is waiting.
        push_a();
        d0 = done_cnt_a;
        start_a = 1'b1;
        start_cyc_a = cyc;
        seen_a = 0;
        step(1);
        start_a = 1'b0;
        step(6);
        out_ready_a = 1'b0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        out_ready_a = 1'b1;
        check_idle_a("midreset_a");
        check("midreset_pending", exp_q_a.size(), 2);
        exp_q_a.delete();
        addr_q_a.delete();
        step(5);
        check("midreset_no_done", done_cnt_a - d0, 0);

        scen_a(-10, 0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/n2r_ctrl.md
# n2r_ctrl

Sequencer for the normal-to-ready reshaping path feeding the Multi MAC matrix multiplier. It reads a row-major matrix from a row-wide source memory in groups of BLOCK_SIZE*NUM_CORES rows, holds each group, then emits it column-block by column-block as NUM_CORES packed BLOCK_SIZE×BLOCK_SIZE chunks over a valid/ready stream. One `start` processes the whole ROW×COL matrix and ends with a `done` pulse.

## Interface
- WIDTH, 16, element width in bits (fixed-point, FRAC_WIDTH carried only by downstream).
- BLOCK_SIZE, 2, systolic block edge.
- CHUNK_SIZE, 4, elements per core chunk; must equal BLOCK_SIZE*BLOCK_SIZE.
- ROW, 4, matrix rows; must be a multiple of G = BLOCK_SIZE*NUM_CORES.
- COL, 6, matrix columns; must be a multiple of BLOCK_SIZE.
- NUM_CORES, 2, parallel MAC cores.
- ADDR_W, 8, row-address width of source memory.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin processing; sampled only in IDLE.
- base_addr  in  ADDR_W  row address of matrix row 0; sampled with start.
- busy  out  1  high in FILL, DRAIN, DONE.
- done  out  1  one-cycle pulse at end of matrix.
- rd_en  out  1  source read strobe.
- rd_addr  out  ADDR_W  source row address.
- rd_data  in  WIDTH*COL  row data, valid exactly 1 cycle after rd_en; element k at bits [WIDTH*(COL-k)-1 -: WIDTH].
- out_data  out  WIDTH*CHUNK_SIZE*NUM_CORES  packed chunks, core 0 in MSBs.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when valid&ready.
- out_last  out  1  high with final chunk of final group.
- stall_cnt  out  32  only under N2R_CTRL_STALL_CNT_EN.

## Operation
- States: IDLE, FILL, DRAIN, DONE. Counters: fill index i (0..G-1), group g (0..ROW/G-1), column block j (0..COL/BLOCK_SIZE-1).
- IDLE: start=1 → latch base_addr, g=0, go FILL.
- FILL: rd_en=1 for G consecutive cycles, rd_addr = base + g*G + i (mod 2^ADDR_W). rd_data captured into buffer[i] the cycle after each read. After last capture → DRAIN with j=0.
- DRAIN: chunk for core c, block j = elements (row c*BLOCK_SIZE+r, col j*BLOCK_SIZE+k), r,k in 0..BLOCK_SIZE-1, row-major, (r=0,k=0) in the chunk MSBs. Chunk held until accepted. Accept with j<last → next j. Accept of last j: g<last → FILL next group; else → DONE.
- DONE: done=1 for one cycle, → IDLE.
- start outside IDLE ignored. rd_data outside capture windows ignored.

## Timing
- Reset: state IDLE, counters 0, busy/done/rd_en/out_valid/out_last 0, rd_addr 0, out_data 0, stall_cnt 0. Buffer contents not reset. Reset mid-operation aborts immediately; no done.
- start in cycle 0 → rd_en cycles 1..G → first out_valid in cycle G+2.
- out_data/out_valid/out_last registered; stable while valid&!ready. Valid never drops without acceptance.
- Back-to-back acceptance within a group: one chunk per cycle.
- Between groups: out_valid low for G+1 cycles (refill; no overlap).
- done asserts the cycle after final acceptance; busy falls the cycle after done.
- ROW=G: single group, FILL→DRAIN→DONE only.

## Configuration
- N2R_CTRL_STALL_CNT_EN defined: stall_cnt port exists; increments (saturating at 2^32-1) every cycle with out_valid&!out_ready; cleared on reset and on accepted start.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package n2r_pkg: state enum, helper constants G = BLOCK_SIZE*NUM_CORES, NUM_COLBLK = COL/BLOCK_SIZE, NUM_GROUPS = ROW/G, counter-width functions.
- Sub-module n2r_chunk_mux: combinational selection of block j from the G-row buffer into the packed out_data word; controller registers its output.

## Test plan
- Defaults, rows r = elements 10r+k, out_ready=1, start at cycle 0 → rd_addr 0..3 cycles 1..4; first chunk cycle 6 = {0,1,10,11 | 20,21,30,31}; 3 chunks; out_last on third; done one cycle later.
- ROW=8, base_addr=0xFE → rd_addr FE,FF,00,01 then 02..05; 6 chunks total; valid gap of 5 cycles between groups.
- out_ready low 4 cycles on chunk 1 → out_data held unchanged; stall_cnt=4 with macro.
- start pulsed during DRAIN → ignored; chunk sequence and done count unchanged.
- rst_n low mid-DRAIN → next cycle all outputs 0, IDLE; fresh start reproduces the first scenario exactly.
